// File: rtl/reg_scoreboard_if.sv
// reg_scoreboard_if: issue, writeback and decode-query bundle between the pipeline and the scoreboard
interface reg_scoreboard_if #(parameter int AW = 5);
  logic          iss0_valid;
  logic [AW-1:0] iss0_dst;
  logic          iss1_valid;
  logic [AW-1:0] iss1_dst;
  logic          wb0_valid;
  logic [AW-1:0] wb0_dst;
  logic          wb1_valid;
  logic [AW-1:0] wb1_dst;
  logic          flush;
  logic [AW-1:0] rs1;
  logic [AW-1:0] rs2;
  logic          rs1_busy;
  logic          rs2_busy;
  logic          iss_stall;
  logic          any_pending;
  logic          err_underflow;
  modport master (
    output iss0_valid, iss0_dst, iss1_valid, iss1_dst,
    output wb0_valid, wb0_dst, wb1_valid, wb1_dst, flush, rs1, rs2,
    input  rs1_busy, rs2_busy, iss_stall, any_pending, err_underflow
  );
  modport slave (
    input  iss0_valid, iss0_dst, iss1_valid, iss1_dst,
    input  wb0_valid, wb0_dst, wb1_valid, wb1_dst, flush, rs1, rs2,
    output rs1_busy, rs2_busy, iss_stall, any_pending, err_underflow
  );
endinterface

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: per-register in-flight write counters with busy, stall and underflow reporting
module reg_scoreboard #(
  parameter int NREG = 32,
  parameter int AW   = 5,
  parameter int CNTW = 2
) (
  input logic            clk,
  input logic            resetn,
  reg_scoreboard_if.slave sb
);
  localparam int W = CNTW + 2;
  localparam logic [W-1:0] MAXC = W'((1 << CNTW) - 1);
  logic [CNTW-1:0] cnt_q [NREG];
  logic [CNTW-1:0] cnt_d [NREG];
  logic [W-1:0]    inc   [NREG];
  logic [W-1:0]    dec   [NREG];
  logic [W-1:0]    sum   [NREG];
  logic            err_q, err_d;
  logic            stall;
  logic            any;
  // Tally per-register issues and writebacks; stall if any counter would exceed its maximum after same-cycle credit
  always_comb begin
    stall = 1'b0;
    for (int r = 0; r < NREG; r++) begin
      inc[r] = (r == 0) ? '0 : W'(sb.iss0_valid && sb.iss0_dst == AW'(r)) + W'(sb.iss1_valid && sb.iss1_dst == AW'(r));
      dec[r] = (r == 0) ? '0 : W'(sb.wb0_valid && sb.wb0_dst == AW'(r)) + W'(sb.wb1_valid && sb.wb1_dst == AW'(r));
      if (((W'(cnt_q[r]) > dec[r]) ? W'(cnt_q[r]) - dec[r] : '0) + inc[r] > MAXC) stall = 1'b1;
    end
  end
  // Next counts: blocked issues contribute nothing, underflow clamps to zero, flush clears without touching the error flag
  always_comb begin
    err_d = err_q;
    for (int r = 0; r < NREG; r++) begin
      sum[r] = W'(cnt_q[r]) + (stall ? '0 : inc[r]);
      cnt_d[r] = (sb.flush || dec[r] > sum[r]) ? '0 : CNTW'(sum[r] - dec[r]);
      if (!sb.flush && dec[r] > sum[r]) err_d = 1'b1;
    end
  end
  // Counter and sticky error state
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q <= '{default: '0};
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
  // Any register still owed a write
  always_comb begin
    any = 1'b0;
    for (int r = 1; r < NREG; r++) any = any | (cnt_q[r] != '0);
  end
  assign sb.rs1_busy      = (sb.rs1 != '0) && (cnt_q[sb.rs1] != '0);
  assign sb.rs2_busy      = (sb.rs2 != '0) && (cnt_q[sb.rs2] != '0);
  assign sb.iss_stall     = stall;
  assign sb.any_pending   = any;
  assign sb.err_underflow = err_q;
endmodule

// File: tb/tb_reg_scoreboard.sv
// tb_reg_scoreboard: directed plan plus randomized traffic checked against a counter-array model
module tb_reg_scoreboard;
  localparam int NREG = 32;
  localparam int MAXC = 3;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  int n_tests = 0;
  int n_fail = 0;
  int m_cnt [NREG] = '{default: 0};
  bit m_err = 1'b0;
  reg_scoreboard_if #(.AW(5)) s ();
  reg_scoreboard #(.NREG(NREG), .AW(5), .CNTW(2)) u_dut (.clk(clk), .resetn(resetn), .sb(s));
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %b, expected %b", nm, $time, act, exp);
    end
  endtask
  function automatic int m_inc(int r);
    return (r != 0 && s.iss0_valid && int'(s.iss0_dst) == r ? 1 : 0) + (r != 0 && s.iss1_valid && int'(s.iss1_dst) == r ? 1 : 0);
  endfunction
  function automatic int m_dec(int r);
    return (r != 0 && s.wb0_valid && int'(s.wb0_dst) == r ? 1 : 0) + (r != 0 && s.wb1_valid && int'(s.wb1_dst) == r ? 1 : 0);
  endfunction
  function automatic bit m_stall();
    for (int r = 1; r < NREG; r++)
      if (((m_cnt[r] > m_dec(r)) ? m_cnt[r] - m_dec(r) : 0) + m_inc(r) > MAXC) return 1'b1;
    return 1'b0;
  endfunction
  function automatic bit m_any();
    for (int r = 1; r < NREG; r++) if (m_cnt[r] != 0) return 1'b1;
    return 1'b0;
  endfunction
  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_cnt = '{default: 0};
      m_err = 1'b0;
    end else if (s.flush) begin
      m_cnt = '{default: 0};
    end else begin
      bit st;
      int v [NREG];
      st = m_stall();
      for (int r = 1; r < NREG; r++) begin
        v[r] = m_cnt[r] + (st ? 0 : m_inc(r)) - m_dec(r);
        if (v[r] < 0) begin
          m_err = 1'b1;
          v[r] = 0;
        end
      end
      for (int r = 1; r < NREG; r++) m_cnt[r] = v[r];
    end
  end
  always @(negedge clk) begin
    chk("rs1_busy", s.rs1_busy, s.rs1 != 0 && m_cnt[s.rs1] != 0);
    chk("rs2_busy", s.rs2_busy, s.rs2 != 0 && m_cnt[s.rs2] != 0);
    chk("any_pending", s.any_pending, m_any());
    chk("iss_stall", s.iss_stall, m_stall());
    chk("err_underflow", s.err_underflow, m_err);
  end
  task automatic clr();
    s.iss0_valid = 0; s.iss0_dst = 0; s.iss1_valid = 0; s.iss1_dst = 0;
    s.wb0_valid = 0; s.wb0_dst = 0; s.wb1_valid = 0; s.wb1_dst = 0; s.flush = 0;
  endtask
  task automatic nxt();
    @(posedge clk);
    #1;
    clr();
  endtask
  initial begin
    clr();
    s.rs1 = 0;
    s.rs2 = 0;
    #1;
    chk("reset_busy", s.rs1_busy, 1'b0);
    chk("reset_pending", s.any_pending, 1'b0);
    chk("reset_err", s.err_underflow, 1'b0);
    #11 resetn = 1'b1;
    s.rs1 = 5;
    nxt(); s.iss0_valid = 1; s.iss0_dst = 5; #1;
    chk("issue_same_cycle_busy", s.rs1_busy, 1'b0);
    nxt(); #1;
    chk("issue_next_cycle_busy", s.rs1_busy, 1'b1);
    nxt(); s.wb0_valid = 1; s.wb0_dst = 5; #1;
    chk("wb_same_cycle_busy", s.rs1_busy, 1'b1);
    nxt(); #1;
    chk("wb_next_cycle_busy", s.rs1_busy, 1'b0);
    chk("wb_next_cycle_pending", s.any_pending, 1'b0);
    s.rs1 = 7;
    nxt(); s.iss0_valid = 1; s.iss0_dst = 7; s.iss1_valid = 1; s.iss1_dst = 7;
    nxt(); s.wb0_valid = 1; s.wb0_dst = 7; #1;
    chk("dual_issue_busy", s.rs1_busy, 1'b1);
    nxt(); s.wb1_valid = 1; s.wb1_dst = 7; #1;
    chk("dual_one_left_busy", s.rs1_busy, 1'b1);
    nxt(); #1;
    chk("dual_drained_busy", s.rs1_busy, 1'b0);
    s.rs1 = 9;
    for (int k = 0; k < 3; k++) begin
      nxt(); s.iss0_valid = 1; s.iss0_dst = 9; #1;
      chk("sat_accept_stall", s.iss_stall, 1'b0);
    end
    nxt(); s.iss0_valid = 1; s.iss0_dst = 9; #1;
    chk("sat_fourth_stall", s.iss_stall, 1'b1);
    nxt(); s.iss0_valid = 1; s.iss0_dst = 9; s.wb0_valid = 1; s.wb0_dst = 9; #1;
    chk("sat_wb_credit_stall", s.iss_stall, 1'b0);
    for (int k = 0; k < 3; k++) begin
      nxt(); s.wb0_valid = 1; s.wb0_dst = 9; #1;
      chk("sat_drain_busy", s.rs1_busy, 1'b1);
    end
    nxt(); #1;
    chk("sat_drained_busy", s.rs1_busy, 1'b0);
    chk("sat_drained_err", s.err_underflow, 1'b0);
    s.rs1 = 0;
    nxt(); s.iss0_valid = 1; s.iss0_dst = 0; s.wb0_valid = 1; s.wb0_dst = 0; #1;
    chk("r0_stall", s.iss_stall, 1'b0);
    nxt(); #1;
    chk("r0_busy", s.rs1_busy, 1'b0);
    chk("r0_pending", s.any_pending, 1'b0);
    chk("r0_err", s.err_underflow, 1'b0);
    nxt(); s.iss0_valid = 1; s.iss0_dst = 3; s.iss1_valid = 1; s.iss1_dst = 4;
    s.rs1 = 3; s.rs2 = 4;
    nxt(); s.flush = 1; s.iss0_valid = 1; s.iss0_dst = 6; s.wb0_valid = 1; s.wb0_dst = 3; #1;
    chk("preflush_busy", s.rs1_busy, 1'b1);
    nxt(); #1;
    chk("flush_rs1_busy", s.rs1_busy, 1'b0);
    chk("flush_rs2_busy", s.rs2_busy, 1'b0);
    chk("flush_pending", s.any_pending, 1'b0);
    chk("flush_err", s.err_underflow, 1'b0);
    s.rs2 = 0;
    nxt(); s.wb1_valid = 1; s.wb1_dst = 12;
    nxt(); #1;
    chk("underflow_err", s.err_underflow, 1'b1);
    nxt(); s.iss0_valid = 1; s.iss0_dst = 5;
    nxt(); #1;
    chk("underflow_sticky", s.err_underflow, 1'b1);
    chk("pending_before_reset", s.any_pending, 1'b1);
    s.rs1 = 5; #1;
    resetn = 1'b0; #1;
    chk("async_reset_busy", s.rs1_busy, 1'b0);
    chk("async_reset_pending", s.any_pending, 1'b0);
    chk("async_reset_err", s.err_underflow, 1'b0);
    for (int blk = 0; blk < 4; blk++) begin
      @(negedge clk); #2 resetn = 1'b1;
      repeat (500) begin
        nxt();
        s.iss0_valid = $urandom_range(0, 1) == 1;
        s.iss1_valid = $urandom_range(0, 2) == 0;
        s.wb0_valid  = $urandom_range(0, 2) == 0;
        s.wb1_valid  = $urandom_range(0, 3) == 0;
        s.iss0_dst = 5'($urandom_range(0, 7) == 0 ? $urandom_range(0, 31) : $urandom_range(0, 3));
        s.iss1_dst = 5'($urandom_range(0, 3));
        s.wb0_dst  = 5'($urandom_range(0, 3));
        s.wb1_dst  = 5'($urandom_range(0, 7) == 0 ? $urandom_range(0, 31) : $urandom_range(0, 3));
        s.flush = $urandom_range(0, 63) == 0;
        s.rs1 = 5'($urandom_range(0, 4));
        s.rs2 = 5'($urandom_range(0, 31));
      end
      #2 resetn = 1'b0;
    end
    @(negedge clk); #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
